// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store bridge onto a 16-bit asynchronous SRAM
// Each access is two half-word SRAM cycles (low then high) plus WAIT_CYCLES of padding.
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_WAIT, S_DONE} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   wr_q;
    logic [SRAM_ADDR_W-2:0] w_q;
    logic [31:0]            wdata_q;
    logic [31:0]            read_data_q;
    logic [SRAM_ADDR_W-1:0] sram_addr_q;
    logic                   we_n_q;
    logic                   dq_oe_q;
    logic [15:0]            dq_out_q;

    // Out-of-range addresses wrap silently into the SRAM window.
    logic [31:0]            offset;
    logic [SRAM_ADDR_W-2:0] word_idx;
    logic                   unused_offset_bits;
    assign offset             = address - BASE_ADDR;
    assign word_idx           = offset[SRAM_ADDR_W:2];
    assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

    // Bus outputs are registered one edge ahead so they line up with LOW/HIGH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            w_q         <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_en | rd_en) begin
                        wr_q        <= wr_en;
                        w_q         <= word_idx;
                        wdata_q     <= write_data;
                        sram_addr_q <= {word_idx, 1'b0};
                        we_n_q      <= ~wr_en;
                        dq_oe_q     <= wr_en;
                        dq_out_q    <= write_data[15:0];
                        state_q     <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (!wr_q) read_data_q[15:0] <= SRAM_DQ;
                    sram_addr_q <= {w_q, 1'b1};
                    dq_out_q    <= wdata_q[31:16];
                    state_q     <= S_HIGH;
                end
                S_HIGH: begin
                    if (!wr_q) read_data_q[31:16] <= SRAM_DQ;
                    we_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                end
                S_WAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready     = ~(wr_en | rd_en) | (state_q == S_DONE);
    assign read_data = read_data_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage bridge between the 32-bit pipeline data path and a 16-bit external SRAM. It turns one word load or store into a fixed-length, two-half-word SRAM sequence and holds the pipeline via `ready` while the access is in flight. Load data it returns goes through write-back into the register file.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `SRAM_ADDR_W`, default 18: SRAM address width, in half-word units.
- `WAIT_CYCLES`, default 2: padding cycles after the high half, modelling SRAM cycle time. Must be ≥ 0.

Ports:
- `clk`, in, 1: single clock; everything updates on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `wr_en`, in, 1: store request, held by the pipeline until `ready`.
- `rd_en`, in, 1: load request, held by the pipeline until `ready`.
- `address`, in, 32: byte address; must be word-aligned.
- `write_data`, in, 32: store data.
- `read_data`, out, 32: load result.
- `ready`, out, 1: high means the pipeline may advance.
- `SRAM_DQ`, inout, 16: SRAM data bus.
- `SRAM_ADDR`, out, `SRAM_ADDR_W`: SRAM half-word address.
- `SRAM_WE_N`, out, 1: SRAM write enable, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`, out, 1 each: tied to 0.

## Operation
- Word index: `w = (address - BASE_ADDR) >> 2`.
  - Subtraction wraps modulo 2^32.
  - The result is truncated so that `{w, 1'b0}` fits in `SRAM_ADDR_W`.
  - No range error is generated.
- Half-word mapping:
  - Low half `[15:0]` is at SRAM address `{w,0}`.
  - High half `[31:16]` is at SRAM address `{w,1}`.
- FSM states: IDLE, LOW, HIGH, WAIT, DONE.
  - IDLE → LOW when `wr_en | rd_en`. The operation (write wins if both are high), `address` and `write_data` are latched at this edge.
  - LOW → HIGH unconditionally.
  - HIGH → WAIT when `WAIT_CYCLES > 0`, otherwise HIGH → DONE.
  - WAIT holds for exactly `WAIT_CYCLES` cycles using an internal counter, then → DONE.
  - DONE → IDLE unconditionally.
- LOW state:
  - `SRAM_ADDR = {w,0}`.
  - Write: `SRAM_DQ = wdata[15:0]`, `SRAM_WE_N = 0`.
  - Read: `SRAM_DQ` is hi-Z, `SRAM_WE_N = 1`, and `read_data[15:0]` is captured from `SRAM_DQ` at the end of the cycle.
- HIGH state: same as LOW with address `{w,1}` and bits `[31:16]`.
- IDLE, WAIT, DONE: `SRAM_WE_N = 1`, `SRAM_DQ` hi-Z, `SRAM_ADDR` holds its last value.
- `ready = ~(wr_en | rd_en) | (state == DONE)`. This is combinational, so a request stalls the pipeline in the same cycle it appears.
- `read_data` is registered. It changes only in LOW/HIGH of a read and holds between reads; a write does not alter it.

## Timing
- Access length, counting the request cycle in IDLE: `4 + WAIT_CYCLES` cycles (6 by default).
- `ready` is low in IDLE (while requested), LOW, HIGH and WAIT, and high only in DONE.
- Full `read_data` is valid during DONE and afterwards.
- In DONE the pipeline advances on that edge. The FSM returns to IDLE, so a new request sampled in the next cycle starts a fresh access with no dead cycle.
- Request inputs are ignored outside IDLE; latched values are used throughout.
- Dropping `wr_en`/`rd_en` mid-access (e.g. on a flush) does not abort the access. It completes; `ready` is already high because the request is gone.
- Reset values:
  - state IDLE; WAIT counter 0.
  - `read_data` = 0.
  - `SRAM_ADDR` = 0.
  - `SRAM_WE_N` = 1.
  - `SRAM_DQ` hi-Z.
- Reset mid-access: the next edge forces IDLE. Any in-progress write may leave a half-written word; this is acceptable.

## Test plan
- Write `0xDEADBEEF` at address 1024:
  - `SRAM_ADDR` is 0 with DQ=`0xBEEF` and WE_N=0, then `SRAM_ADDR` is 1 with DQ=`0xDEAD`.
  - `ready` is low for 5 cycles and high in cycle 6.
- Read address 1024 from an SRAM model holding the previous write: `read_data = 0xDEADBEEF` in DONE, with `ready` high in exactly that cycle.
- Address 1028 maps to SRAM addresses 2 then 3.
- `wr_en = rd_en = 1` with data `0x12345678`: a write is performed (WE_N pulses) and `read_data` is unchanged.
- Back-to-back read → write → read with no gap:
  - Each access takes 6 cycles.
  - The second read returns the written value.
  - DQ is never driven during reads.
- `rst` asserted during HIGH of a write: next cycle is IDLE with WE_N=1, DQ hi-Z, `read_data=0`, and `ready=1` once the request drops.
